// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the Wishbone bridge blocks: the master FSM state
// encoding, the default error-read value and the response record handed to
// the host-link encoder.
package wb_bridge_pkg;

  // Master FSM states: wait for a command, run the bus cycle, present the
  // response, then one forced idle cycle so the slave can drop ack.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } wb_state_e;

  // Data returned for a read that no slave acknowledged.
  localparam logic [31:0] WB_ERR_DATA = 32'hDEAD_C0DE;

  // Data width of the response record shared with the host-link encoder.
  localparam int unsigned WB_RSP_DATA_WIDTH = 32;

  // One response beat as seen by the host link.
  typedef struct packed {
    logic [WB_RSP_DATA_WIDTH-1:0] dat;
    logic                         err;
    logic                         we;
  } wb_rsp_t;

endpackage

// File: rtl/wb_interface.sv
// Wishbone classic point-to-point bundle. Naming follows the slave's view:
// dat_i is write data into the slave, dat_o is read data out of the slave.
// The master also forwards its clock and reset on the bundle.
interface wb_interface #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32
);

  logic                     clk;
  logic                     rst;
  logic [ADDRESS_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0]    dat_i;
  logic [DATA_WIDTH-1:0]    dat_o;
  logic                     we;
  logic                     stb;
  logic                     cyc;
  logic                     ack;

  modport master (
    output clk, rst, adr, dat_i, we, stb, cyc,
    input  dat_o, ack
  );

  modport slave (
    input  clk, rst, adr, dat_i, we, stb, cyc,
    output dat_o, ack
  );

endinterface

// File: rtl/wb_stream_master.sv
// Single-beat Wishbone classic master. Each accepted command runs exactly one
// bus cycle and produces exactly one response. A cycle that is never acked
// is closed by a timeout and reported with the error flag, so a missing
// crossbar target cannot hang the bus.
module wb_stream_master
  import wb_bridge_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDRESS_WIDTH  = 32,
  parameter int unsigned           TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(WB_ERR_DATA)
) (
  input  logic                     clk,
  input  logic                     rst,
  // command channel
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [ADDRESS_WIDTH-1:0] cmd_adr,
  input  logic [DATA_WIDTH-1:0]    cmd_dat,
  // response channel
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_dat,
  output logic                     rsp_err,
  output logic                     rsp_we,
  // bus
  wb_interface.master              m_wb,
  // statistics
  output logic [31:0]              cnt_done,
  output logic [31:0]              cnt_timeout
);

  // The timer counts BUS cycles without ack; 16 bits covers the full
  // 1..65535 timeout range. The cycle is abandoned in the cycle where the
  // timer equals TO_LAST, which makes cyc high for exactly TIMEOUT_CYCLES.
  localparam int unsigned TIMER_WIDTH = 16;
  localparam logic [TIMER_WIDTH-1:0] TO_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  wb_state_e                r_state;
  logic [TIMER_WIDTH-1:0]   r_timer;
  logic                     r_cyc;
  logic                     r_we;
  logic [ADDRESS_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0]    r_dat;
  logic                     r_rsp_valid;
  logic [DATA_WIDTH-1:0]    r_rsp_dat;
  logic                     r_rsp_err;
  logic                     r_rsp_we;
  logic [31:0]              r_cnt_done;
  logic [31:0]              r_cnt_timeout;

  logic                     w_ack;
  logic                     w_timeout;

  // Only a clean 1 is an ack; an undriven or unknown ack from an unmapped
  // decode falls through to the timeout path.
  assign w_ack     = (m_wb.ack == 1'b1);
  assign w_timeout = (r_timer == TO_LAST);

  // Command, response and bus-cycle sequencing with registered outputs.
  // NOTE: all state here uses non-blocking assignments so every branch reads
  // the pre-edge values; a blocking update would leak into later decisions
  // of the same edge. The reset branch is asynchronous, so cyc/stb fall the
  // moment rst rises rather than at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_timer       <= '0;
      r_cyc         <= 1'b0;
      r_we          <= 1'b0;
      r_adr         <= '0;
      r_dat         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_dat     <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_we      <= 1'b0;
      r_cnt_done    <= '0;
      r_cnt_timeout <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_adr   <= cmd_adr;
            r_dat   <= cmd_dat;
            r_we    <= cmd_we;
            r_cyc   <= 1'b1;
            r_timer <= '0;
            r_state <= BUS;
          end
        end

        BUS: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (w_ack) begin
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_dat   <= r_we ? '0 : m_wb.dat_o;
            r_rsp_err   <= 1'b0;
            r_rsp_we    <= r_we;
            r_state     <= RESP;
          end else if (w_timeout) begin
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_dat   <= r_we ? '0 : ERR_DATA;
            r_rsp_err   <= 1'b1;
            r_rsp_we    <= r_we;
            r_state     <= RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cnt_done  <= r_cnt_done + 32'd1;
            if (r_rsp_err) begin
              r_cnt_timeout <= r_cnt_timeout + 32'd1;
            end
            r_state <= GAP;
          end
        end

        GAP: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Ready is a decode of the registered state, gated so it reads 0 while
  // reset is held.
  assign cmd_ready = (r_state == IDLE) && !rst;

  assign rsp_valid   = r_rsp_valid;
  assign rsp_dat     = r_rsp_dat;
  assign rsp_err     = r_rsp_err;
  assign rsp_we      = r_rsp_we;
  assign cnt_done    = r_cnt_done;
  assign cnt_timeout = r_cnt_timeout;

  assign m_wb.clk   = clk;
  assign m_wb.rst   = rst;
  assign m_wb.cyc   = r_cyc;
  assign m_wb.stb   = r_cyc;
  assign m_wb.we    = r_we;
  assign m_wb.adr   = r_adr;
  assign m_wb.dat_i = r_dat;

endmodule

// File: tb/tb_wb_stream_master.sv
// Bench for wb_stream_master: a scripted slave acks at a chosen BUS cycle
// (or never), and each transaction is compared with a reference model that
// derives response data, error flag, cycle length and latency directly from
// the ack position and the timeout limit.
module tb_wb_stream_master;
  import wb_bridge_pkg::*;

  localparam int          DW  = 32;
  localparam int          AW  = 32;
  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'hDEAD_C0DE;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_dat;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;
  logic          rsp_we;
  logic [31:0]   cnt_done;
  logic [31:0]   cnt_timeout;

  wb_interface #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) wb_if ();

  wb_stream_master #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_we(rsp_we),
    .m_wb(wb_if),
    .cnt_done(cnt_done), .cnt_timeout(cnt_timeout)
  );

  int          checks = 0;
  int          failures = 0;
  int unsigned exp_done = 0;
  int unsigned exp_to = 0;
  int          cyc_no = 0;

  // Slave script: ack in BUS cycle sl_ack_at (1-based), 0 = never ack.
  int          sl_ack_at = 0;
  logic [31:0] sl_dat = '0;
  logic        sl_idle_ack = 1'b0;
  int          sl_n = 0;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic        we;
    int          lat;
    int          len;
    bit          bus_ok;
    bit          rsp_ok;
    bit          ready_ok;
    bit          gap_ok;
    bit          to;
  } obs_t;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_no <= cyc_no + 1;

  // Slave responder, updated on the falling edge so the DUT sees stable ack.
  always @(negedge clk) begin
    wb_if.dat_o <= sl_dat;
    if (wb_if.cyc) begin
      sl_n       <= sl_n + 1;
      wb_if.ack  <= (sl_ack_at != 0) && (sl_n + 1 == sl_ack_at);
    end else begin
      sl_n      <= 0;
      wb_if.ack <= sl_idle_ack;
    end
  end

  // Reference: what one transaction must produce.
  function automatic void model(input logic we, input int ack_at, input logic [31:0] sd,
                                output logic [31:0] d, output logic e, output int len);
    e   = (ack_at == 0) || (ack_at > TO);
    len = e ? TO : ack_at;
    if (we) d = '0;
    else if (e) d = ERR;
    else d = sd;
  endfunction

  // Drive one command, observe the bus cycle and response, consume the
  // response after `hold` stall cycles, and follow the GAP/IDLE cycles.
  task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input int ack_at, input logic [31:0] sd, input int hold,
                         output obs_t o);
    int n;
    bit got;
    logic [31:0] md;
    logic me;
    int ml;
    o = '0;
    model(we, ack_at, sd, md, me, ml);
    sl_ack_at = ack_at;
    sl_dat    = sd;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat;
    n = 0; got = 0;
    while (!got && n < 50) begin
      @(negedge clk); n++;
      if (cmd_ready) got = 1;
    end
    if (!got) begin o.to = 1; cmd_valid = 1'b0; return; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_we = 1'($urandom_range(0, 1)); cmd_adr = $urandom; cmd_dat = $urandom;
    o.bus_ok = 1; o.ready_ok = 1; n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk); n++;
      if (cmd_ready !== 1'b0) o.ready_ok = 0;
      if (wb_if.cyc === 1'b1) begin
        o.len++;
        if (wb_if.stb !== 1'b1 || wb_if.adr !== adr || wb_if.dat_i !== dat || wb_if.we !== we)
          o.bus_ok = 0;
      end
      if (rsp_valid === 1'b1) got = 1;
    end
    if (!got) begin o.to = 1; return; end
    o.lat = n; o.dat = rsp_dat; o.err = rsp_err; o.we = rsp_we; o.rsp_ok = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_dat !== o.dat || rsp_err !== o.err || rsp_we !== o.we ||
          wb_if.cyc !== 1'b0 || cmd_ready !== 1'b0)
        o.rsp_ok = 0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_done++;
    if (me) exp_to++;
    @(negedge clk);
    o.gap_ok = (cmd_ready === 1'b0) && (wb_if.cyc === 1'b0) && (rsp_valid === 1'b0);
    @(negedge clk);
    if (cmd_ready !== 1'b1) o.gap_ok = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_we !== 1'b0 || rsp_dat !== '0) begin
      failures++; $display("FAIL reset_rsp got valid=%b err=%b we=%b dat=%h exp all 0", rsp_valid, rsp_err, rsp_we, rsp_dat); end
    checks++; if (wb_if.cyc !== 1'b0 || wb_if.stb !== 1'b0 || wb_if.we !== 1'b0 || wb_if.adr !== '0 || wb_if.dat_i !== '0) begin
      failures++; $display("FAIL reset_bus got cyc=%b stb=%b we=%b adr=%h dat_i=%h exp all 0", wb_if.cyc, wb_if.stb, wb_if.we, wb_if.adr, wb_if.dat_i); end
    checks++; if (cnt_done !== 32'd0 || cnt_timeout !== 32'd0) begin
      failures++; $display("FAIL reset_counters got done=%0d to=%0d exp 0 0", cnt_done, cnt_timeout); end
    checks++; if (wb_if.rst !== 1'b1) begin failures++; $display("FAIL reset_wb_rst got=%b exp=1", wb_if.rst); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL idle_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write;
    obs_t o;
    run_cmd(1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 4, $urandom, 0, o);
    checks++; if (o.to) begin failures++; $display("FAIL write_handshake got=no_response exp=response"); end
    checks++; if (o.len != 4) begin failures++; $display("FAIL write_cyc_len got=%0d exp=4", o.len); end
    checks++; if (!o.bus_ok) begin failures++; $display("FAIL write_bus_fields got=unstable exp=adr 404 dat_i DEADBEEF we 1"); end
    checks++; if (o.err !== 1'b0 || o.we !== 1'b1 || o.dat !== 32'd0) begin
      failures++; $display("FAIL write_rsp got err=%b we=%b dat=%h exp 0 1 0", o.err, o.we, o.dat); end
    checks++; if (o.lat != 5) begin failures++; $display("FAIL write_latency got=%0d exp=5", o.lat); end
    checks++; if (cnt_done !== exp_done) begin failures++; $display("FAIL write_cnt_done got=%0d exp=%0d", cnt_done, exp_done); end
    checks++; if (!o.gap_ok || !o.ready_ok) begin failures++; $display("FAIL write_gap got gap=%b ready_low=%b exp 1 1", o.gap_ok, o.ready_ok); end
  endtask

  task automatic test_read;
    obs_t o;
    run_cmd(1'b0, 32'h0000_0010, $urandom, 1, 32'h1234_5678, 0, o);
    checks++; if (o.lat != 2) begin failures++; $display("FAIL read_latency got=%0d exp=2", o.lat); end
    checks++; if (o.dat !== 32'h1234_5678 || o.err !== 1'b0 || o.we !== 1'b0) begin
      failures++; $display("FAIL read_rsp got dat=%h err=%b we=%b exp 12345678 0 0", o.dat, o.err, o.we); end
    checks++; if (o.len != 1) begin failures++; $display("FAIL read_cyc_len got=%0d exp=1", o.len); end
  endtask

  task automatic test_timeout;
    obs_t o;
    run_cmd(1'b0, 32'h8000_0000, $urandom, 0, $urandom, 2, o);
    checks++; if (o.len != TO) begin failures++; $display("FAIL timeout_cyc_len got=%0d exp=%0d", o.len, TO); end
    checks++; if (o.err !== 1'b1 || o.dat !== ERR) begin
      failures++; $display("FAIL timeout_rsp got err=%b dat=%h exp 1 %h", o.err, o.dat, ERR); end
    checks++; if (cnt_timeout !== exp_to || exp_to != 1) begin
      failures++; $display("FAIL timeout_cnt got=%0d exp=1", cnt_timeout); end
    checks++; if (!o.rsp_ok) begin failures++; $display("FAIL timeout_rsp_hold got=unstable exp=stable"); end
    run_cmd(1'b1, 32'h8000_0004, $urandom, 0, $urandom, 0, o);
    checks++; if (o.err !== 1'b1 || o.dat !== 32'd0 || o.we !== 1'b1) begin
      failures++; $display("FAIL timeout_write got err=%b dat=%h we=%b exp 1 0 1", o.err, o.dat, o.we); end
  endtask

  task automatic test_ack_at_timeout;
    obs_t o;
    run_cmd(1'b0, 32'h0000_0020, $urandom, TO, 32'hA5A5_0001, 0, o);
    checks++; if (o.err !== 1'b0 || o.dat !== 32'hA5A5_0001 || o.len != TO) begin
      failures++; $display("FAIL coincident_ack got err=%b dat=%h len=%0d exp 0 a5a50001 %0d", o.err, o.dat, o.len, TO); end
    run_cmd(1'b0, 32'h0000_0024, $urandom, TO + 1, 32'hA5A5_0002, 0, o);
    checks++; if (o.err !== 1'b1 || o.dat !== ERR || o.len != TO) begin
      failures++; $display("FAIL late_ack got err=%b dat=%h len=%0d exp 1 %h %0d", o.err, o.dat, o.len, ERR, TO); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] adrs [3];
    int acc_at [3];
    int accepts, n;
    bit got, held_ok, gap_ok, order_ok, rsp_ok;
    accepts = 0; held_ok = 1; gap_ok = 1; order_ok = 1; rsp_ok = 1;
    for (int k = 0; k < 3; k++) begin adrs[k] = 32'h100 + 32'(k * 4); acc_at[k] = 0; end
    sl_ack_at = 1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = adrs[0]; cmd_dat = $urandom;
    for (int k = 0; k < 3; k++) begin
      n = 0; got = 0;
      while (!got && n < 60) begin @(negedge clk); n++; if (cmd_ready) got = 1; end
      if (!got) break;
      acc_at[k] = cyc_no; accepts++;
      @(posedge clk); #1;
      if (k < 2) begin cmd_adr = adrs[k+1]; cmd_dat = $urandom; end
      else cmd_valid = 1'b0;
      n = 0; got = 0;
      while (!got && n < 60) begin
        @(negedge clk); n++;
        if (wb_if.cyc === 1'b1 && wb_if.adr !== adrs[k]) order_ok = 0;
        if (rsp_valid === 1'b1) got = 1;
      end
      if (!got) break;
      if (rsp_err !== 1'b0 || rsp_we !== 1'b1 || rsp_dat !== 32'd0) rsp_ok = 0;
      if (k == 0) begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'd0 || cmd_ready !== 1'b0 ||
              wb_if.cyc !== 1'b0)
            held_ok = 0;
        end
        rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      exp_done++;
      @(negedge clk);
      if (wb_if.cyc !== 1'b0 || cmd_ready !== 1'b0) gap_ok = 0;
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    checks++; if (accepts != 3) begin failures++; $display("FAIL b2b_accepts got=%0d exp=3", accepts); end
    checks++; if (!held_ok) begin failures++; $display("FAIL b2b_stall got=changed exp=stable with no accept"); end
    checks++; if (!gap_ok) begin failures++; $display("FAIL b2b_gap got=busy exp=cyc 0 ready 0"); end
    checks++; if (!order_ok || !rsp_ok) begin failures++; $display("FAIL b2b_order got order=%b rsp=%b exp 1 1", order_ok, rsp_ok); end
    checks++; if (acc_at[2] - acc_at[1] != 4) begin
      failures++; $display("FAIL b2b_spacing got=%0d exp=4", acc_at[2] - acc_at[1]); end
    checks++; if (cnt_done !== exp_done) begin failures++; $display("FAIL b2b_cnt_done got=%0d exp=%0d", cnt_done, exp_done); end
  endtask

  task automatic test_idle_ack;
    bit ok;
    ok = 1;
    sl_idle_ack = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (wb_if.cyc !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || cnt_done !== exp_done) ok = 0;
    end
    sl_idle_ack = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL idle_ack got=reacted exp=ignored"); end
  endtask

  task automatic test_random;
    obs_t o;
    logic we;
    logic [31:0] adr, dat, sd, md;
    int ack_at, hold, ml, bad;
    logic me;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      we = 1'($urandom_range(0, 1)); adr = $urandom; dat = $urandom; sd = $urandom;
      ack_at = $urandom_range(0, TO + 4); hold = $urandom_range(0, 3);
      model(we, ack_at, sd, md, me, ml);
      run_cmd(we, adr, dat, ack_at, sd, hold, o);
      checks++;
      if (o.to || o.dat !== md || o.err !== me || o.we !== we || o.len != ml || o.lat != ml + 1 ||
          !o.bus_ok || !o.rsp_ok || !o.gap_ok || !o.ready_ok) begin
        failures++; bad++;
        $display("FAIL random_%0d got dat=%h err=%b we=%b len=%0d lat=%0d exp dat=%h err=%b we=%b len=%0d lat=%0d",
                 i, o.dat, o.err, o.we, o.len, o.lat, md, me, we, ml, ml + 1);
      end
    end
    checks++; if (cnt_done !== exp_done || cnt_timeout !== exp_to) begin
      failures++; $display("FAIL random_counters got done=%0d to=%0d exp %0d %0d", cnt_done, cnt_timeout, exp_done, exp_to); end
  endtask

  task automatic test_reset_mid_bus;
    obs_t o;
    int n;
    bit got, quiet;
    sl_ack_at = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0000_0030; cmd_dat = $urandom;
    n = 0; got = 0;
    while (!got && n < 50) begin @(negedge clk); n++; if (cmd_ready) got = 1; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (wb_if.cyc !== 1'b1) begin failures++; $display("FAIL rst_pre_bus got cyc=%b exp=1", wb_if.cyc); end
    rst = 1'b1;
    #1;
    checks++; if (wb_if.cyc !== 1'b0 || wb_if.stb !== 1'b0) begin
      failures++; $display("FAIL rst_async_drop got cyc=%b stb=%b exp 0 0", wb_if.cyc, wb_if.stb); end
    exp_done = 0; exp_to = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    quiet = 1;
    repeat (TO + 4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || wb_if.cyc !== 1'b0) quiet = 0;
    end
    checks++; if (!quiet) begin failures++; $display("FAIL rst_no_rsp got=activity exp=quiet"); end
    checks++; if (cnt_done !== 32'd0 || cnt_timeout !== 32'd0) begin
      failures++; $display("FAIL rst_counters got done=%0d to=%0d exp 0 0", cnt_done, cnt_timeout); end
    run_cmd(1'b0, 32'h0000_0034, $urandom, 3, 32'h0BAD_F00D, 1, o);
    checks++; if (o.dat !== 32'h0BAD_F00D || o.err !== 1'b0 || o.lat != 4 || cnt_done !== 32'd1) begin
      failures++; $display("FAIL rst_recover got dat=%h err=%b lat=%0d done=%0d exp 0badf00d 0 4 1", o.dat, o.err, o.lat, cnt_done); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; rsp_ready = 1'b0;
    test_reset;
    test_write;
    test_read;
    test_timeout;
    test_ack_at_timeout;
    test_back_to_back;
    test_idle_ack;
    test_random;
    test_reset_mid_bus;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=time_limit exp=completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/wb_stream_master.md
Name: wb_stream_master

Overview:
- Wishbone bus master that sits directly upstream of the Wishbone crossbar and drives its slave-side port.
- Accepts single-beat register commands (read or write) on a valid/ready command channel, typically from the host-link packet decoder.
- Runs exactly one Wishbone classic cycle per command and returns one response per command on a valid/ready response channel.
- Unmapped addresses, where no crossbar target ever acks, terminate by timeout with an error flag, so the bus never hangs.

Parameters:
DATA_WIDTH, 32, width of Wishbone data and of cmd/rsp data.
ADDRESS_WIDTH, 32, width of Wishbone address and of cmd_adr.
TIMEOUT_CYCLES, 255, maximum number of cycles cyc/stb stay asserted without ack; range 1..65535.
ERR_DATA, 32'hDEAD_C0DE, value returned on rsp_dat for a timed-out read.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
cmd_we  input  1  1 = write, 0 = read.
cmd_adr  input  ADDRESS_WIDTH  byte-agnostic register address, passed unchanged to the bus.
cmd_dat  input  DATA_WIDTH  write data (ignored for reads).
rsp_valid  output  1  response present.
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
rsp_dat  output  DATA_WIDTH  read data; 0 for writes; ERR_DATA for timed-out reads.
rsp_err  output  1  1 = cycle timed out.
rsp_we  output  1  echo of the command's cmd_we.
m_wb  interface  wb_interface.master  drives clk, rst, adr, dat_i, we, stb, cyc; samples dat_o, ack.
cnt_done  output  32  number of completed transactions, wrapping.
cnt_timeout  output  32  number of timed-out transactions, wrapping.

Behaviour:
- Interface wiring: m_wb.clk = clk, m_wb.rst = rst, combinationally.
- Reset values (rst high, asynchronous): state=IDLE, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_we=0, rsp_dat=0, m_wb.cyc=0, m_wb.stb=0, m_wb.we=0, m_wb.adr=0, m_wb.dat_i=0, both counters 0.
- Reset mid-cycle drops cyc/stb immediately (asynchronously). Any pending response is discarded.
- FSM states: IDLE, BUS, RESP, GAP.
- IDLE:
  - cmd_ready=1.
  - On handshake, register adr, dat_i and we; go to BUS next cycle with cyc=stb=1; timeout counter=0.
- BUS:
  - cyc=stb=1; adr, dat_i and we held stable.
  - Each cycle with ack==1'b1 ends the cycle. Register rsp_dat = (we ? 0 : m_wb.dat_o), rsp_err=0, then go to RESP.
  - Any ack value other than 1 (0, X, Z from an unmapped crossbar decode) is not an ack.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 without ack: rsp_err=1, rsp_dat = (we ? 0 : ERR_DATA), go to RESP.
  - cyc/stb therefore stay high for at most TIMEOUT_CYCLES cycles.
  - Ack in the same cycle as the timeout: ack wins, err=0.
- RESP:
  - cyc=stb=0; rsp_valid=1; rsp_dat, rsp_err and rsp_we stable until rsp_ready.
  - On handshake: cnt_done += 1, and cnt_timeout += 1 if rsp_err. Go to GAP.
- GAP:
  - One mandatory idle cycle (cyc=0, cmd_ready=0) so the slave's ack can fall before the next cycle. Then go to IDLE.
- Latency: a command accepted at cycle t has cyc high from t+1. With ack at cycle t+k (k≥1), rsp_valid rises at t+k+1.
- Minimum command spacing is 4 cycles (IDLE, BUS, RESP, GAP).
- Ack arriving while cyc=0 is ignored.
- Counters wrap from 2^32-1 to 0.
- Exactly one response per accepted command; commands and responses stay in order with no overlap.
- cmd_ready is 0 in BUS, RESP and GAP.

Decomposition:
- Shared package wb_bridge_pkg holds:
  - the state enum (IDLE, BUS, RESP, GAP);
  - the default ERR_DATA constant;
  - a response struct {dat, err, we} reused by the host-link encoder.
- No sub-module: the timeout counter and FSM are both small and local.
- The block connects to the existing wb_interface.

Test Plan:
- Write 0x0000_0404 / 0xDEADBEEF; slave acks 3 cycles after cyc rises -> cyc/stb high 4 cycles; we=1, dat_i=0xDEADBEEF, adr=0x404; rsp: err=0, we=1, dat=0; cnt_done=1.
- Read 0x0000_0010; slave returns 0x1234_5678 with ack on the first BUS cycle -> rsp_valid 2 cycles after the cmd handshake; rsp_dat=0x12345678, err=0.
- TIMEOUT_CYCLES=16, read unmapped 0x8000_0000 (ack stays Z) -> cyc high exactly 16 cycles; rsp_err=1, rsp_dat=0xDEADC0DE; cnt_timeout=1.
- Back-to-back: cmd_valid held for 3 commands with rsp_ready=0 for 10 cycles -> only the first accepted; rsp stable for 10 cycles; GAP cycle seen with cyc=0 between bus cycles.
- Ack and timeout coincident, with TIMEOUT_CYCLES=4 and ack in the 4th BUS cycle -> err=0, dat from slave.
- Assert rst 2 cycles into BUS -> cyc/stb low in the same cycle; no rsp_valid after release; counters=0; next command executes normally.
